// File: rtl/nios_sys_nios2_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : nios_sys_nios2_cpu_ocimem_arbiter
// Desc   : Round-robin arbiter sharing the OCI RAM port between JTAG and Avalon.
// Rev    : 1.0
// ============================================================================
module nios_sys_nios2_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ACCESS   = 2'd1;
  localparam logic [1:0] c_CAPTURE  = 2'd2;
  localparam logic [1:0] c_RESP     = 2'd3;
  localparam logic       c_OWN_JTAG = 1'b0;
  localparam logic       c_OWN_AVS  = 1'b1;

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mon;
  logic              r_ready;
  logic              r_overrun;
  logic              r_pend;
  logic              r_slot_wr;
  logic [ADDR_W-1:0] r_slot_addr;
  logic [DATA_W-1:0] r_slot_wdata;

  logic              w_jtag_done;
  logic              w_jtag_accept;
  logic              w_jtag_pend;
  logic              w_avs_pend;
  logic              w_grant_jtag;
  logic              w_grant_avs;
  logic              w_j_wr;
  logic [ADDR_W-1:0] w_j_addr;
  logic [DATA_W-1:0] w_j_wdata;

  assign w_jtag_done   = (r_state == c_RESP) && (r_owner == c_OWN_JTAG);
  assign w_jtag_accept = jtag_req && (!r_pend || w_jtag_done);
  // A fresh strobe seen in IDLE is granted on the same edge it is latched.
  assign w_jtag_pend   = r_pend || jtag_req;
  assign w_j_wr        = r_pend ? r_slot_wr    : jtag_wr;
  assign w_j_addr      = r_pend ? r_slot_addr  : jtag_addr;
  assign w_j_wdata     = r_pend ? r_slot_wdata : jtag_wdata;
  assign w_avs_pend    = avs_read || avs_write;
  assign w_grant_jtag  = w_jtag_pend && (!w_avs_pend || (r_last_grant == c_OWN_AVS));
  assign w_grant_avs   = w_avs_pend && !w_grant_jtag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_owner      <= c_OWN_AVS;
      r_last_grant <= c_OWN_AVS;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_mon        <= '0;
      r_ready      <= 1'b0;
      r_overrun    <= 1'b0;
      r_pend       <= 1'b0;
      r_slot_wr    <= 1'b0;
      r_slot_addr  <= '0;
      r_slot_wdata <= '0;
    end else begin
      if (w_jtag_accept) begin
        r_pend       <= 1'b1;
        r_slot_wr    <= jtag_wr;
        r_slot_addr  <= jtag_addr;
        r_slot_wdata <= jtag_wdata;
      end else if (w_jtag_done) begin
        r_pend <= 1'b0;
      end

      if (jtag_req && !w_jtag_accept) r_overrun <= 1'b1;

      // A new request accepted on the completion edge wins over completion.
      if (w_jtag_accept)    r_ready <= 1'b0;
      else if (w_jtag_done) r_ready <= 1'b1;

      case (r_state)
        c_IDLE: begin
          if (w_grant_jtag) begin
            r_state      <= c_ACCESS;
            r_owner      <= c_OWN_JTAG;
            r_last_grant <= c_OWN_JTAG;
            r_wr         <= w_j_wr;
            r_addr       <= w_j_addr;
            r_wdata      <= w_j_wdata;
          end else if (w_grant_avs) begin
            r_state      <= c_ACCESS;
            r_owner      <= c_OWN_AVS;
            r_last_grant <= c_OWN_AVS;
            r_wr         <= avs_write;
            r_addr       <= avs_address;
            r_wdata      <= avs_writedata;
          end
        end
        c_ACCESS:  r_state <= r_wr ? c_RESP : c_CAPTURE;
        c_CAPTURE: begin
          r_rdata <= ram_rdata;
          r_state <= c_RESP;
        end
        c_RESP: begin
          if ((r_owner == c_OWN_JTAG) && !r_wr) r_mon <= r_rdata;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign ram_we          = (r_state == c_ACCESS) && r_wr;
  assign ram_re          = (r_state == c_ACCESS) && !r_wr;
  assign ram_addr        = r_addr;
  assign ram_wdata       = r_wdata;
  assign avs_waitrequest = !((r_state == c_RESP) && (r_owner == c_OWN_AVS));
  assign avs_readdata    = r_rdata;
  assign MonDReg         = r_mon;
  assign monitor_ready   = r_ready;
  assign jtag_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nios_sys_nios2_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_nios_sys_nios2_cpu_ocimem_arbiter
// Desc   : Scoreboard bench for the OCI RAM arbiter with a 1-cycle RAM model.
// Rev    : 1.0
// ============================================================================
module tb_nios_sys_nios2_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        jtag_req, jtag_wr;
  logic [7:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic        avs_read, avs_write;
  logic [7:0]  avs_address;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata = 32'h0;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;

  logic        bk_we = 1'b0;
  logic [7:0]  bk_addr = 8'h0;
  logic [31:0] bk_data = 32'h0;
  logic [31:0] mem [0:255];

  typedef struct packed { logic we; logic [7:0] addr; logic [31:0] data; } ram_exp_t;
  typedef struct packed { logic rd; logic [31:0] data; } avs_exp_t;
  ram_exp_t    q_ram[$];
  avs_exp_t    q_avs[$];
  logic [31:0] q_mon[$];
  ram_exp_t    e_ram;
  avs_exp_t    e_avs;
  logic [31:0] e_mon;
  logic        prev_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_sys_nios2_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .jtag_overrun(jtag_overrun)
  );

  // RAM model: read data appears one cycle after ram_re
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected one", name);
  endtask

  function automatic void push_ram(input logic we, input logic [7:0] a, input logic [31:0] d);
    ram_exp_t t;
    t.we = we; t.addr = a; t.data = d;
    q_ram.push_back(t);
  endfunction

  function automatic void push_avs(input logic rd, input logic [31:0] d);
    avs_exp_t t;
    t.rd = rd; t.data = d;
    q_avs.push_back(t);
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output event
  always @(negedge clk) begin
    if (ram_we || ram_re) begin
      chk("ram_one_hot", {31'h0, ram_we & ram_re}, 32'h0);
      if (q_ram.size() == 0) fail_now("ram_unexpected_access");
      else begin
        e_ram = q_ram.pop_front();
        chk("ram_we", {31'h0, ram_we}, {31'h0, e_ram.we});
        chk("ram_addr", {24'h0, ram_addr}, {24'h0, e_ram.addr});
        if (e_ram.we) chk("ram_wdata", ram_wdata, e_ram.data);
      end
    end
    if (!avs_waitrequest) begin
      if (q_avs.size() == 0) fail_now("avs_unexpected_response");
      else begin
        e_avs = q_avs.pop_front();
        if (e_avs.rd) chk("avs_readdata", avs_readdata, e_avs.data);
      end
    end
    if (monitor_ready && !prev_rdy) begin
      if (q_mon.size() == 0) fail_now("mon_unexpected_ready");
      else begin
        e_mon = q_mon.pop_front();
        chk("MonDReg", MonDReg, e_mon);
      end
    end
    prev_rdy <= monitor_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_strobe(input logic wr, input logic [7:0] a, input logic [31:0] d);
    jtag_req = 1'b1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
    step();
    jtag_req = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    bit seen = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (monitor_ready) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("monitor_ready_timeout");
    step();
  endtask

  // Holds the request until waitrequest is seen low; lat counts high cycles
  task automatic avs_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [31:0] d, output int lat);
    bit done = 1'b0;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin done = 1'b1; break; end
      lat++;
    end
    if (!done) fail_now("avs_waitrequest_timeout");
    step();
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    bit found;
    reset = 1'b1;
    jtag_req = 1'b0; jtag_wr = 1'b0; jtag_addr = 8'h0; jtag_wdata = 32'h0;
    avs_read = 1'b0; avs_write = 1'b0; avs_address = 8'h0; avs_writedata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      bk_we = 1'b1;
      bk_addr = i[7:0];
      bk_data = (i == 5) ? 32'h12345678 : 32'h0;
      step();
    end
    bk_we = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_waitrequest", {31'h0, avs_waitrequest}, 32'h1);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_re", {31'h0, ram_re}, 32'h0);
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_ready", {31'h0, monitor_ready}, 32'h0);
    chk("rst_overrun", {31'h0, jtag_overrun}, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    step();

    // JTAG write then read of 0x10
    push_ram(1'b1, 8'h10, 32'hDEADBEEF); q_mon.push_back(32'h0);
    jtag_strobe(1'b1, 8'h10, 32'hDEADBEEF);
    wait_ready(n);
    push_ram(1'b0, 8'h10, 32'h0); q_mon.push_back(32'hDEADBEEF);
    jtag_strobe(1'b0, 8'h10, 32'h0);
    wait_ready(n);
    chk("jtag_rd_ready_latency", n, 4);
    chk("overrun_after_jtag", {31'h0, jtag_overrun}, 32'h0);

    // Avalon read, write, read+write-as-write, cross reads
    push_ram(1'b0, 8'h05, 32'h0); push_avs(1'b1, 32'h12345678);
    avs_access(1'b1, 1'b0, 8'h05, 32'h0, lat);
    chk("avs_rd_latency", lat, 3);
    @(negedge clk);
    chk("avs_wreq_high_after_rd", {31'h0, avs_waitrequest}, 32'h1);
    step();
    push_ram(1'b1, 8'h20, 32'hCAFEF00D); push_avs(1'b0, 32'h0);
    avs_access(1'b0, 1'b1, 8'h20, 32'hCAFEF00D, lat);
    chk("avs_wr_latency", lat, 2);
    push_ram(1'b1, 8'h21, 32'h0BADF00D); push_avs(1'b0, 32'h0);
    avs_access(1'b1, 1'b1, 8'h21, 32'h0BADF00D, lat);
    chk("avs_both_latency", lat, 2);
    push_ram(1'b0, 8'h20, 32'h0); q_mon.push_back(32'hCAFEF00D);
    jtag_strobe(1'b0, 8'h20, 32'h0);
    wait_ready(n);
    push_ram(1'b0, 8'h21, 32'h0); push_avs(1'b1, 32'h0BADF00D);
    avs_access(1'b1, 1'b0, 8'h21, 32'h0, lat);

    // Simultaneous requests after reset: JTAG, AVS, JTAG, AVS
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk);
    chk("rst2_MonDReg", MonDReg, 32'h0);
    chk("rst2_ready", {31'h0, monitor_ready}, 32'h0);
    step();
    push_ram(1'b1, 8'h30, 32'h11111111); push_ram(1'b1, 8'h31, 32'h22222222);
    q_mon.push_back(32'h0); push_avs(1'b0, 32'h0);
    fork
      jtag_strobe(1'b1, 8'h30, 32'h11111111);
      avs_access(1'b0, 1'b1, 8'h31, 32'h22222222, lat);
    join
    chk("tie1_avs_latency", lat, 5);
    push_ram(1'b1, 8'h32, 32'h33333333); push_ram(1'b1, 8'h33, 32'h44444444);
    q_mon.push_back(32'h0); push_avs(1'b0, 32'h0);
    fork
      jtag_strobe(1'b1, 8'h32, 32'h33333333);
      avs_access(1'b0, 1'b1, 8'h33, 32'h44444444, lat);
    join
    chk("tie2_avs_latency", lat, 5);

    // Second strobe while pending is dropped and sets the sticky flag
    push_ram(1'b1, 8'h40, 32'h55555555); q_mon.push_back(32'h0);
    jtag_strobe(1'b1, 8'h40, 32'h55555555);
    jtag_strobe(1'b1, 8'h41, 32'h66666666);
    @(negedge clk);
    chk("overrun_set", {31'h0, jtag_overrun}, 32'h1);
    wait_ready(n);
    push_ram(1'b0, 8'h41, 32'h0); q_mon.push_back(32'h0);
    jtag_strobe(1'b0, 8'h41, 32'h0);
    wait_ready(n);
    push_ram(1'b0, 8'h40, 32'h0); q_mon.push_back(32'h55555555);
    jtag_strobe(1'b0, 8'h40, 32'h0);
    wait_ready(n);
    @(negedge clk);
    chk("overrun_sticky", {31'h0, jtag_overrun}, 32'h1);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk);
    chk("overrun_cleared_by_reset", {31'h0, jtag_overrun}, 32'h0);
    step();

    // Reset during ACCESS of an Avalon read aborts it; the held read re-issues
    push_ram(1'b0, 8'h05, 32'h0); push_ram(1'b0, 8'h05, 32'h0);
    push_avs(1'b1, 32'h12345678);
    fork
      avs_access(1'b1, 1'b0, 8'h05, 32'h0, lat);
      begin
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (ram_re) begin found = 1'b1; break; end
        end
        if (!found) fail_now("abort_access_not_seen");
        else begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          @(negedge clk);
          chk("abort_ram_re", {31'h0, ram_re}, 32'h0);
          chk("abort_waitrequest", {31'h0, avs_waitrequest}, 32'h1);
        end
      end
    join
    chk("abort_reissue_latency", lat, 5);

    repeat (3) step();
    chk("q_ram_drained", q_ram.size(), 32'h0);
    chk("q_avs_drained", q_avs.size(), 32'h0);
    chk("q_mon_drained", q_mon.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
